// File: rtl/rc_realign_gearbox.sv
// RC completion gearbox: strips the 3-DW descriptor and realigns payload to DW0.
// Optional length check against byte_count is enabled with RC_GEARBOX_LEN_CHECK_EN.
module rc_realign_gearbox #(
  parameter int DATA_WIDTH  = 256,
  parameter int TUSER_WIDTH = 75,
  parameter int SOP_BIT     = 32,
  parameter int BC_LSB      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    m_axis_rc_tdata,
  input  logic                     m_axis_rc_tvalid,
  input  logic [TUSER_WIDTH-1:0]   m_axis_rc_tuser,
  input  logic [DATA_WIDTH/32-1:0] m_axis_rc_tkeep,
  input  logic                     m_axis_rc_tlast,
  output logic                     m_axis_rc_tready,
  input  logic                     rc_ready,
  output logic                     rc_valid,
  output logic [DATA_WIDTH-1:0]    rc_payload,
  output logic [DATA_WIDTH/32-1:0] rc_payload_dw_keep,
  output logic                     rc_payload_last,
  output logic [95:0]              rc_descriptor,
  output logic                     rc_proto_err
`ifdef RC_GEARBOX_LEN_CHECK_EN
  , output logic                   rc_len_err
`endif
);
  localparam int N  = DATA_WIDTH / 32;
  localparam int CW = $clog2(N + 1) + 1;
  localparam int RW = DATA_WIDTH - 96;

  typedef enum logic [1:0] {IDLE, BODY, FLUSH} state_t;

  state_t                state_q, state_d;
  logic                  valid_q, last_q, perr_q, perr_d;
  logic [DATA_WIDTH-1:0] payload_q;
  logic [N-1:0]          keep_q;
  logic [95:0]           desc_q, desc_d;
  logic [RW-1:0]         res_q, res_d;
  logic [CW-1:0]         rcnt_q, rcnt_d;

  logic                  ld, ld_last;
  logic [DATA_WIDTH-1:0] ld_pay;
  logic [N-1:0]          ld_keep;
  logic [CW-1:0]         k, k3;
  logic                  out_free, accept, sop;
  logic                  unused_tuser;

  function automatic logic [N-1:0] dw_mask(input logic [CW-1:0] n);
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] expand(input logic [N-1:0] m);
    logic [DATA_WIDTH-1:0] e;
    for (int i = 0; i < N; i++) e[i*32 +: 32] = {32{m[i]}};
    return e;
  endfunction

  assign unused_tuser     = ^m_axis_rc_tuser;
  assign sop              = m_axis_rc_tuser[SOP_BIT];
  assign out_free         = !valid_q || rc_ready;
  assign m_axis_rc_tready = out_free && (state_q != FLUSH);
  assign accept           = m_axis_rc_tvalid && m_axis_rc_tready;

  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) k = k + CW'(m_axis_rc_tkeep[i]);
    k3 = (k > CW'(3)) ? k - CW'(3) : '0;
  end

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_pay  = '0;
    ld_keep = '0;
    ld_last = 1'b0;
    res_d   = res_q;
    rcnt_d  = rcnt_q;
    desc_d  = desc_q;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (sop) begin
          desc_d = m_axis_rc_tdata[95:0];
          res_d  = m_axis_rc_tdata[DATA_WIDTH-1:96];
          rcnt_d = k3;
          if (m_axis_rc_tlast) begin
            ld      = 1'b1;
            ld_pay  = {96'b0, m_axis_rc_tdata[DATA_WIDTH-1:96]};
            ld_keep = dw_mask(k3);
            ld_last = 1'b1;
          end else begin
            state_d = BODY;
          end
        end else begin
          perr_d = 1'b1;
        end
      end
      BODY: if (accept) begin
        perr_d  = sop;
        ld      = 1'b1;
        ld_pay  = {m_axis_rc_tdata[95:0], res_q};
        ld_keep = '1;
        res_d   = m_axis_rc_tdata[DATA_WIDTH-1:96];
        rcnt_d  = k3;
        if (m_axis_rc_tlast) begin
          if (k <= CW'(3)) begin
            ld_keep = dw_mask(CW'(N - 3) + k);
            ld_last = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: if (out_free) begin
        ld      = 1'b1;
        ld_pay  = {96'b0, res_q};
        ld_keep = dw_mask(rcnt_q);
        ld_last = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      perr_q    <= 1'b0;
      payload_q <= '0;
      keep_q    <= '0;
      desc_q    <= '0;
      res_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      state_q <= state_d;
      perr_q  <= perr_d;
      desc_q  <= desc_d;
      res_q   <= res_d;
      rcnt_q  <= rcnt_d;
      if (ld) begin
        valid_q   <= 1'b1;
        payload_q <= ld_pay & expand(ld_keep);
        keep_q    <= ld_keep;
        last_q    <= ld_last;
      end else if (rc_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef RC_GEARBOX_LEN_CHECK_EN
  logic [15:0] cnt_q, cnt_d, nd, cnt_base, bc_rnd;
  logic [12:0] bc_cur;
  logic        lerr_q;

  // Byte tally restarts with the SOP beat, which is always decided in IDLE.
  always_comb begin
    nd = '0;
    for (int i = 0; i < N; i++) nd = nd + 16'(ld_keep[i]);
    cnt_base = (state_q == IDLE) ? 16'd0 : cnt_q;
    bc_cur   = (state_q == IDLE) ? m_axis_rc_tdata[BC_LSB +: 13] : desc_q[BC_LSB +: 13];
    cnt_d    = cnt_base + {nd[13:0], 2'b00};
    bc_rnd   = ({3'b0, bc_cur} + 16'd3) & 16'hFFFC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      lerr_q <= 1'b0;
    end else if (ld) begin
      cnt_q  <= cnt_d;
      lerr_q <= ld_last && (bc_rnd != cnt_d);
    end
  end

  assign rc_len_err = lerr_q;
`endif

  assign rc_valid           = valid_q;
  assign rc_payload         = payload_q;
  assign rc_payload_dw_keep = keep_q;
  assign rc_payload_last    = last_q;
  assign rc_descriptor      = desc_q;
  assign rc_proto_err       = perr_q;
endmodule

// File: tb/tb_rc_realign_gearbox.sv
// Directed bench for rc_realign_gearbox at N=8: vector table plus stall sequence.
module tb_rc_realign_gearbox;
  logic         clk = 0;
  logic         rst;
  logic [255:0] tdata;
  logic         tvalid;
  logic [74:0]  tuser;
  logic [7:0]   tkeep;
  logic         tlast;
  logic         tready;
  logic         rdy;
  logic         ovalid;
  logic [255:0] opay;
  logic [7:0]   okeep;
  logic         olast;
  logic [95:0]  odesc;
  logic         operr;
`ifdef RC_GEARBOX_LEN_CHECK_EN
  logic         olerr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc_realign_gearbox dut (
    .clk(clk), .rst(rst),
    .m_axis_rc_tdata(tdata), .m_axis_rc_tvalid(tvalid), .m_axis_rc_tuser(tuser),
    .m_axis_rc_tkeep(tkeep), .m_axis_rc_tlast(tlast), .m_axis_rc_tready(tready),
    .rc_ready(rdy), .rc_valid(ovalid), .rc_payload(opay),
    .rc_payload_dw_keep(okeep), .rc_payload_last(olast),
    .rc_descriptor(odesc), .rc_proto_err(operr)
`ifdef RC_GEARBOX_LEN_CHECK_EN
    , .rc_len_err(olerr)
`endif
  );

  typedef struct {
    logic         rst, rdy, tv, sop, last;
    logic [7:0]   keep;
    logic [255:0] data;
    logic         e_trdy, e_v;
    logic [255:0] e_pay;
    logic [7:0]   e_keep;
    logic         e_last, e_perr;
    logic [95:0]  e_desc;
  } rec_t;

  rec_t vecs[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [15:0] tag);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i*32 +: 32] = {tag, 16'(i)};
    return b;
  endfunction

  function automatic logic [95:0] mkdesc(input logic [31:0] tag, input logic [12:0] bc);
    logic [95:0] d;
    d = '0;
    d[95:64] = tag;
    d[28:16] = bc;
    d[7:0]   = 8'h5A;
    return d;
  endfunction

  task automatic add(input logic r, input logic rd, input logic tv, input logic s, input logic l,
                     input logic [7:0] kp, input logic [255:0] d, input logic et, input logic ev,
                     input logic [255:0] ep, input logic [7:0] ek, input logic el, input logic eperr,
                     input logic [95:0] ed);
    rec_t x;
    x.rst = r; x.rdy = rd; x.tv = tv; x.sop = s; x.last = l; x.keep = kp; x.data = d;
    x.e_trdy = et; x.e_v = ev; x.e_pay = ep; x.e_keep = ek; x.e_last = el;
    x.e_perr = eperr; x.e_desc = ed;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic tv, input logic s, input logic l, input logic [7:0] kp,
                       input logic [255:0] d);
    tvalid = tv; tlast = l; tkeep = kp; tdata = d;
    tuser = '0; tuser[32] = s;
  endtask

  logic [255:0] bA, bB, b2B, bC, b2C, bD, bR, b2R, bS, b2S, b3S, junk;
  logic [159:0] pA, pB, pC, pR, pS;
  logic [95:0]  dA, dB, dC, dD, dR, dS;
  logic [255:0] cap_pay[$];
  logic [7:0]   cap_keep[$];
  logic         cap_last[$];
  logic         cap_lerr;

  initial begin
    rst = 1; rdy = 1; drive(0, 0, 0, 8'h00, '0);
    bA = mk(16'hA100); pA = bA[159:0]; dA = mkdesc(32'hDE5C_000A, 13'd20);
    bB = mk(16'hB100); pB = bB[159:0]; dB = mkdesc(32'hDE5C_000B, 13'd52); b2B = mk(16'hB200);
    bC = mk(16'hC100); pC = bC[159:0]; dC = mkdesc(32'hDE5C_000C, 13'd32); b2C = mk(16'hC200);
    bD = mk(16'hD400); dD = mkdesc(32'hDE5C_000D, 13'd0);
    bR = mk(16'hE100); pR = bR[159:0]; dR = mkdesc(32'hDE5C_000E, 13'd52); b2R = mk(16'hE200);
    bS = mk(16'hF100); pS = bS[159:0]; dS = mkdesc(32'hDE5C_000F, 13'd52);
    b2S = mk(16'hF200); b3S = mk(16'hF300); junk = mk(16'h0BAD);

    // rst rd tv sop last keep data | trdy v payload keep last perr desc
    add(0,1,1,1,1,8'hFF,{pA,dA},      1,1,{96'b0,pA},           8'h1F,1,0,dA);
    add(0,1,1,1,0,8'hFF,{pB,dB},      1,0,'0,                   8'h00,0,0,dB);
    add(0,1,1,0,1,8'hFF,b2B,          1,1,{b2B[95:0],pB},       8'hFF,0,0,dB);
    add(0,1,0,0,0,8'h00,'0,           0,1,{96'b0,b2B[255:96]},  8'h1F,1,0,dB);
    add(0,1,0,0,0,8'h00,'0,           1,0,'0,                   8'h00,0,0,dB);
    add(0,1,1,1,0,8'hFF,{pC,dC},      1,0,'0,                   8'h00,0,0,dC);
    add(0,1,1,0,1,8'h07,b2C,          1,1,{b2C[95:0],pC},       8'hFF,1,0,dC);
    add(0,1,0,0,0,8'h00,'0,           1,0,'0,                   8'h00,0,0,dC);
    add(0,1,1,1,1,8'h07,{bD[159:0],dD},1,1,'0,                  8'h00,1,0,dD);
    add(0,1,1,0,1,8'hFF,junk,         1,0,'0,                   8'h00,0,1,dD);
    add(0,1,0,0,0,8'h00,'0,           1,0,'0,                   8'h00,0,0,dD);
    add(0,1,1,1,0,8'hFF,{pR,dR},      1,0,'0,                   8'h00,0,0,dR);
    add(0,1,1,0,0,8'hFF,b2R,          1,1,{b2R[95:0],pR},       8'hFF,0,0,dR);
    add(1,0,1,0,0,8'hFF,junk,         0,0,'0,                   8'h00,0,0,'0);
    add(0,1,1,1,1,8'hFF,{pA,dA},      1,1,{96'b0,pA},           8'h1F,1,0,dA);
    add(0,1,0,0,0,8'h00,'0,           1,0,'0,                   8'h00,0,0,dA);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 256'(ovalid), 256'(1'b0));
    chk("rst_payload", opay, '0);
    chk("rst_keep", 256'(okeep), '0);
    chk("rst_last", 256'(olast), '0);
    chk("rst_desc", 256'(odesc), '0);
    chk("rst_perr", 256'(operr), '0);
    chk("rst_tready", 256'(tready), 256'(1'b1));
    rst = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; rdy = vecs[i].rdy;
      drive(vecs[i].tv, vecs[i].sop, vecs[i].last, vecs[i].keep, vecs[i].data);
      #1 chk($sformatf("v%0d_tready", i), 256'(tready), 256'(vecs[i].e_trdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 256'(ovalid), 256'(vecs[i].e_v));
      chk($sformatf("v%0d_perr", i), 256'(operr), 256'(vecs[i].e_perr));
      if (vecs[i].e_v || vecs[i].rst)
        chk($sformatf("v%0d_last", i), 256'(olast), 256'(vecs[i].e_last));
      if (vecs[i].e_v) begin
        chk($sformatf("v%0d_payload", i), opay, vecs[i].e_pay);
        chk($sformatf("v%0d_keep", i), 256'(okeep), 256'(vecs[i].e_keep));
        chk($sformatf("v%0d_desc", i), 256'(odesc), 256'(vecs[i].e_desc));
`ifdef RC_GEARBOX_LEN_CHECK_EN
        if (vecs[i].e_last) chk($sformatf("v%0d_lenerr", i), 256'(olerr), '0);
`endif
      end
      rst = 0;
    end

    // Three-beat completion with downstream stalled for three cycles.
    begin
      logic [255:0] beats[3];
      logic [255:0] hp;
      logic [7:0]   hk;
      logic         hl, hold;
      int idx, cyc;
      beats[0] = {pS, dS}; beats[1] = b2S; beats[2] = b3S;
      idx = 0; cyc = 0; hold = 0; hp = '0; hk = '0; hl = 0; cap_lerr = 0;
      while (cap_pay.size() < 3 && cyc < 40) begin
        @(negedge clk);
        rdy = !(cyc >= 2 && cyc <= 4);
        if (idx < 3) drive(1, idx == 0, idx == 2, 8'hFF, beats[idx]);
        else drive(0, 0, 0, 8'h00, '0);
        #1;
        if (hold) begin
          chk("stall_hold_pay", opay, hp);
          chk("stall_hold_keep", 256'(okeep), 256'(hk));
          chk("stall_hold_last", 256'(olast), 256'(hl));
        end
        if (ovalid && !rdy) chk("stall_tready", 256'(tready), '0);
        if (ovalid && rdy) begin
          cap_pay.push_back(opay); cap_keep.push_back(okeep); cap_last.push_back(olast);
`ifdef RC_GEARBOX_LEN_CHECK_EN
          if (olast) cap_lerr = olerr;
`endif
        end
        hold = ovalid && !rdy; hp = opay; hk = okeep; hl = olast;
        if (tvalid && tready) idx++;
        @(posedge clk);
        cyc++;
      end
      chk("stall_beat_count", 256'(cap_pay.size()), 256'(3));
      if (cap_pay.size() == 3) begin
        chk("stall_b0_pay", cap_pay[0], {b2S[95:0], pS});
        chk("stall_b0_keep", 256'(cap_keep[0]), 256'(8'hFF));
        chk("stall_b0_last", 256'(cap_last[0]), '0);
        chk("stall_b1_pay", cap_pay[1], {b3S[95:0], b2S[255:96]});
        chk("stall_b1_keep", 256'(cap_keep[1]), 256'(8'hFF));
        chk("stall_b1_last", 256'(cap_last[1]), '0);
        chk("stall_b2_pay", cap_pay[2], {96'b0, b3S[255:96]});
        chk("stall_b2_keep", 256'(cap_keep[2]), 256'(8'h1F));
        chk("stall_b2_last", 256'(cap_last[2]), 256'(1'b1));
`ifdef RC_GEARBOX_LEN_CHECK_EN
        chk("stall_lenerr", 256'(cap_lerr), 256'(1'b1));
`endif
      end
      @(negedge clk);
      drive(0, 0, 0, 8'h00, '0); rdy = 1;
      #1 chk("stall_idle_tready", 256'(tready), 256'(1'b1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
